seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle, registered ALU for the datapath. It replaces the purely combinational one-hot ALU and has these features:
- a binary opcode instead of one-hot strobes;
- a start/done handshake;
- registered results, with `result_hi` defined for every op;
- iterative signed multiply and divide sharing one shift engine;
- status flags.

It sits between the operand registers (Y and bus) and the Z/HI/LO capture registers. The control unit waits on `done` before latching.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Must be ≥ 8 and a power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived; do not override).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `op`  in  4  opcode (`alu_op_t`).
- `a`  in  WIDTH  operand A (bus side).
- `b`  in  WIDTH  operand B: shift amount, divisor or multiplier.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; results valid in the same cycle and held until the next accepted `start`.
- `result_lo`  out  WIDTH  primary result, or quotient for DIV.
- `result_hi`  out  WIDTH  MUL upper half, or remainder for DIV; 0 for all other ops.
- `cout`  out  1  carry out (ADD) or no-borrow (SUB); 0 for other ops.
- `zero`  out  1  `result_lo`==0.
- `err`  out  1  divide-by-zero or illegal opcode.

## Operation
Ops and encodings:
- ADD 0: a+b.
- SUB 1: a−b.
- AND 2.
- OR 3.
- NEG 4: 0−b.
- NOT 5: ~b.
- SHR 6: logical right shift of a.
- SHRA 7: arithmetic right shift of a.
- SHL 8: left shift of a.
- ROR 9.
- ROL 10.
- MUL 11.
- DIV 12.
- 13–15: illegal.

Rules:
- Shift and rotate amount is `b[SHW-1:0]`; upper bits of b are ignored. An amount of 0 passes `a` through unchanged.
- MUL: signed two's complement, radix-2 Booth algorithm, 2·WIDTH-bit product split as {hi, lo}.
- DIV: signed non-restoring division, then a one-cycle sign fix-up:
  - quotient truncates toward zero;
  - remainder takes the sign of the dividend.
- Divide by zero (b==0): no iteration. Result is lo = all-ones, hi = a, `err`=1.
- Illegal opcode: lo = hi = 0, `err`=1.
- Operands and `op` are captured into internal registers at `start`. Input changes while `busy` have no effect.

FSM states:
- IDLE
  - `start` with a single-cycle op → FIN.
  - `start` with MUL, or DIV with b≠0 → ITER.
  - `start` with DIV and b==0 → FIN.
- ITER: count decrements from WIDTH−1.
  - Reaches 0 with MUL → FIN.
  - Reaches 0 with DIV → FIX.
- FIX: DIV sign correction → FIN.
- FIN: load output registers, pulse `done` → IDLE.

Boundary conditions:
- `start` while `busy` is ignored; nothing is queued.
- `start` in the same cycle as `done` is accepted, so back-to-back operation is allowed.
- Most-negative ÷ −1 returns lo = most-negative, hi = 0, `err`=0 (wraps).

## Timing
- `start` accepted at edge t.
  - Single-cycle ops, DIV by 0, illegal ops: `done` at t+1.
  - MUL: `done` at t+WIDTH+1.
  - DIV: `done` at t+WIDTH+2.
- `busy` is high for cycles t+1 … done−1. It is never high in a cycle where `done` is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: every output is 0 and the FSM is IDLE.
- Reset asserted mid-operation aborts immediately: no `done`, and outputs clear to 0 asynchronously.
- The first `start` is accepted on the first rising edge after `rst_n` deasserts.

## Structure
- Package `seq_alu_pkg`:
  - `alu_op_t` enum (4-bit, the encodings above);
  - `alu_state_t` enum (IDLE, ITER, FIX, FIN);
  - `OP_LAST_LEGAL` = 12.
- Sub-module `seq_alu_muldiv`:
  - shared iterative engine with a 2·WIDTH accumulator, counter and sign fix-up;
  - ports: `clk`, `rst_n`, `load`, `is_div`, `a`, `b`, `last`, `hi`, `lo`.
- Top level contains: the FSM, the single-cycle combinational ops, the output registers and the flags.

## Test plan
All scenarios run with WIDTH=32.
- MUL a=−3 (0xFFFFFFFD), b=7 → lo=0xFFFFFFEB, hi=0xFFFFFFFF, `done` exactly at t+33, `busy` high t+1…t+32.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1), `done` at t+34. DIV a=0x80000000, b=−1 → lo=0x80000000, hi=0, `err`=0.
- DIV a=5, b=0 → `done` at t+1, `err`=1, lo=0xFFFFFFFF, hi=5.
- Rotates and shifts:
  - ROL a=0x80000001, b=4 → 0x00000018;
  - ROR a=1, b=0x21 (amount 1) → 0x80000000;
  - SHRA a=0x80000000, b=4 → 0xF8000000.
  - In every case hi=0.
- ADD a=0xFFFFFFFF, b=1 → lo=0, `cout`=1, `zero`=1. SUB a=3, b=5 → 0xFFFFFFFE, `cout`=0.
- Handshake and reset:
  - `start` pulsed at t+5 during a MUL is ignored; the result is unchanged.
  - `rst_n` low at t+10 of a MUL → all outputs 0 and no `done`.
  - A fresh ADD after reset completes in 1 cycle.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu shared types: opcodes, FSM states.
// Imported by the ALU top and its bench.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_NEG  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHR  = 4'd6,
    OP_SHRA = 4'd7,
    OP_SHL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_ROL  = 4'd10,
    OP_MUL  = 4'd11,
    OP_DIV  = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    FIN
  } alu_state_t;

  localparam int OP_LAST_LEGAL = 12;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Shared shift engine: Booth multiply and non-restoring divide
// on magnitudes, with a sign fix-up pass after the last divide step.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] m;
  logic             qm1;
  logic             div_mode;
  logic             run;
  logic             fix;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   m_sx;
  logic [WIDTH:0]   m_zx;
  logic [WIDTH:0]   booth;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_r;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    m_sx  = {m[WIDTH-1], m};
    m_zx  = {1'b0, m};
    a_abs = a[WIDTH-1] ? -a : a;
    b_abs = b[WIDTH-1] ? -b : b;
    case ({acc_lo[0], qm1})
      2'b01:   booth = acc_hi + m_sx;
      2'b10:   booth = acc_hi - m_sx;
      default: booth = acc_hi;
    endcase
    div_sh = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_r  = acc_hi[WIDTH] ? div_sh + m_zx : div_sh - m_zx;
    // a negative partial remainder still owes one divisor back
    rem    = acc_hi[WIDTH] ? acc_hi[WIDTH-1:0] + m
                           : acc_hi[WIDTH-1:0];
  end

  assign last = run && (cnt == '0);
  assign hi   = acc_hi[WIDTH-1:0];
  assign lo   = acc_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      m        <= '0;
      qm1      <= 1'b0;
      div_mode <= 1'b0;
      run      <= 1'b0;
      fix      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      div_mode <= is_div;
      run      <= 1'b1;
      fix      <= 1'b0;
      cnt      <= CW'(WIDTH - 1);
      qm1      <= 1'b0;
      acc_hi   <= '0;
      if (is_div) begin
        acc_lo <= a_abs;
        m      <= b_abs;
        neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r  <= a[WIDTH-1];
      end else begin
        acc_lo <= a;
        m      <= b;
        neg_q  <= 1'b0;
        neg_r  <= 1'b0;
      end
    end else if (run) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        run <= 1'b0;
        fix <= div_mode;
      end
      if (div_mode) begin
        acc_hi <= div_r;
        acc_lo <= {acc_lo[WIDTH-2:0], ~div_r[WIDTH]};
      end else begin
        acc_hi <= {booth[WIDTH], booth[WIDTH:1]};
        acc_lo <= {booth[0], acc_lo[WIDTH-1:1]};
        qm1    <= acc_lo[0];
      end
    end else if (fix) begin
      fix    <= 1'b0;
      acc_hi <= {1'b0, neg_r ? -rem : rem};
      acc_lo <= neg_q ? -acc_lo : acc_lo;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle registered ALU: FSM, single-cycle ops, flags.
// MUL/DIV are delegated to the shared muldiv engine.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  alu_state_t       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             iter_in;
  logic             eng_load;
  logic             eng_last;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;

  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_c;
  logic             res_err;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh;
  logic [SHW:0]     inv;
  logic             illegal;

  assign iter_in  = (op == OP_MUL) ||
                    ((op == OP_DIV) && (b != '0));
  assign eng_load = (state == IDLE) && start && iter_in;

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (eng_load),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .last   (eng_last),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );

  assign illegal = op_q > 4'(OP_LAST_LEGAL);

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_c   = 1'b0;
    res_err = illegal;
    sum     = '0;
    sh      = b_q[SHW-1:0];
    inv     = (SHW+1)'(WIDTH) - {1'b0, sh};
    case (op_q)
      OP_ADD: begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        res_lo = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
      end
      OP_SUB: begin
        sum    = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
        res_lo = sum[WIDTH-1:0];
        res_c  = sum[WIDTH];
      end
      OP_AND:  res_lo = a_q & b_q;
      OP_OR:   res_lo = a_q | b_q;
      OP_NEG:  res_lo = -b_q;
      OP_NOT:  res_lo = ~b_q;
      OP_SHR:  res_lo = a_q >> sh;
      OP_SHRA: res_lo = $signed(a_q) >>> sh;
      OP_SHL:  res_lo = a_q << sh;
      OP_ROR:  res_lo = (a_q >> sh) | (a_q << inv);
      OP_ROL:  res_lo = (a_q << sh) | (a_q >> inv);
      OP_MUL: begin
        res_lo = eng_lo;
        res_hi = eng_hi;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_lo  = '1;
          res_hi  = a_q;
          res_err = 1'b1;
        end else begin
          res_lo = eng_lo;
          res_hi = eng_hi;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
            busy <= 1'b1;
            unique case (1'b1)
              iter_in: state <= ITER;
              default: state <= FIN;
            endcase
          end
        end
        ITER: begin
          if (eng_last)
            state <= (op_q == OP_DIV) ? FIX : FIN;
        end
        FIX: state <= FIN;
        FIN: begin
          result_lo <= res_lo;
          result_hi <= res_hi;
          cout      <= res_c;
          zero      <= (res_lo == '0);
          err       <= res_err;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver pushes expected results,
// monitor pops and compares on every done pulse.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, cout, zero, err;
  logic [31:0] result_lo, result_hi;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        cout;
    logic        err;
    int          lat;
    int          acc;
    logic [3:0]  op;
  } exp_t;

  exp_t scb[$];
  exp_t got;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .cout      (cout),
    .zero      (zero),
    .err       (err)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t mk(input logic [31:0] lo, hi,
                              input logic c, e, input int lat);
    exp_t r;
    r.lo = lo; r.hi = hi; r.cout = c; r.err = e;
    r.lat = lat; r.acc = 0; r.op = '0;
    return r;
  endfunction

  // reference model straight from the op definitions
  function automatic exp_t model(input logic [3:0] o,
                                 input logic [31:0] x, y);
    exp_t   r;
    int     s, sx, sy;
    longint p, q, rm;
    logic [63:0] t;
    r = mk('0, '0, 1'b0, 1'b0, 1);
    s = int'(y[4:0]);
    sx = x;
    sy = y;
    case (o)
      4'd0: begin
        t = {32'b0, x} + {32'b0, y};
        r.lo = t[31:0];
        r.cout = t[32];
      end
      4'd1: begin r.lo = x - y; r.cout = (x >= y); end
      4'd2: r.lo = x & y;
      4'd3: r.lo = x | y;
      4'd4: r.lo = 32'd0 - y;
      4'd5: r.lo = ~y;
      4'd6: r.lo = x >> s;
      4'd7: r.lo = sx >>> s;
      4'd8: r.lo = x << s;
      4'd9: begin
        t = {32'b0, x} << (32 - s);
        r.lo = (x >> s) | t[31:0];
      end
      4'd10: r.lo = (x << s) | (x >> (32 - s));
      4'd11: begin
        p = longint'(sx) * longint'(sy);
        {r.hi, r.lo} = p;
        r.lat = 33;
      end
      4'd12: begin
        if (y == 0) begin
          r.lo = '1; r.hi = x; r.err = 1'b1;
        end else begin
          q = longint'(sx) / longint'(sy);
          rm = longint'(sx) % longint'(sy);
          r.lo = q[31:0];
          r.hi = rm[31:0];
          r.lat = 34;
        end
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, y,
                       input exp_t e);
    start = 1'b1; op = o; a = x; b = y;
    e.acc = cyc + 1;
    e.op = o;
    scb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL timeout: done=%b required 1 within 100 cycles", done);
  endtask

  task automatic run(input logic [3:0] o, input logic [31:0] x, y,
                     input exp_t e);
    issue(o, x, y, e);
    wait_done();
  endtask

  task automatic chk_clear(input string nm);
    n_cmp++;
    if ({busy, done, cout, zero, err} != 5'b0 ||
        result_lo != 0 || result_hi != 0) begin
      n_fail++;
      $display("FAIL %s: busy=%b done=%b lo=%h hi=%h c=%b z=%b e=%b required all 0",
               nm, busy, done, result_lo, result_hi, cout, zero, err);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        n_cmp++;
        if (scb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done=1 required 0 (cyc %0d)", cyc);
        end else begin
          got = scb.pop_front();
          if (result_lo !== got.lo || result_hi !== got.hi ||
              cout !== got.cout || err !== got.err ||
              zero !== (got.lo == 0)) begin
            n_fail++;
            $display("FAIL result op=%0d: got lo=%h hi=%h c=%b z=%b e=%b required lo=%h hi=%h c=%b z=%b e=%b",
                     got.op, result_lo, result_hi, cout, zero, err,
                     got.lo, got.hi, got.cout, got.lo == 0, got.err);
          end
          n_cmp++;
          if (cyc - got.acc != got.lat) begin
            n_fail++;
            $display("FAIL latency op=%0d: got %0d required %0d",
                     got.op, cyc - got.acc, got.lat);
          end
        end
        n_cmp++;
        if (busy) begin
          n_fail++;
          $display("FAIL busy_with_done: busy=1 required 0");
        end
      end else if (scb.size() > 0 && cyc >= scb[0].acc) begin
        n_cmp++;
        if (!busy) begin
          n_fail++;
          $display("FAIL busy_during_op: busy=0 required 1 (cyc %0d)", cyc);
        end
      end else if (scb.size() == 0) begin
        n_cmp++;
        if (busy) begin
          n_fail++;
          $display("FAIL busy_idle: busy=1 required 0 (cyc %0d)", cyc);
        end
      end
    end
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] x, y;

    #2;
    chk_clear("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run(OP_ADD,  32'hFFFFFFFF, 32'h1, mk(32'h0, 32'h0, 1'b1, 1'b0, 1));
    run(OP_SUB,  32'h3, 32'h5, mk(32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1));
    run(OP_ROL,  32'h80000001, 32'h4, mk(32'h18, 32'h0, 1'b0, 1'b0, 1));
    run(OP_ROR,  32'h1, 32'h21, mk(32'h80000000, 32'h0, 1'b0, 1'b0, 1));
    run(OP_SHRA, 32'h80000000, 32'h4, mk(32'hF8000000, 32'h0, 1'b0, 1'b0, 1));
    run(OP_SHL,  32'h12345678, 32'h40, mk(32'h12345678, 32'h0, 1'b0, 1'b0, 1));
    run(OP_MUL,  32'hFFFFFFFD, 32'h7,
        mk(32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 33));
    run(OP_DIV,  32'hFFFFFFF9, 32'h2,
        mk(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34));
    run(OP_DIV,  32'h80000000, 32'hFFFFFFFF,
        mk(32'h80000000, 32'h0, 1'b0, 1'b0, 34));
    run(OP_DIV,  32'h5, 32'h0, mk(32'hFFFFFFFF, 32'h5, 1'b0, 1'b1, 1));
    run(4'd13,   32'h5, 32'h6, mk(32'h0, 32'h0, 1'b0, 1'b1, 1));

    // start pulsed mid-MUL must be dropped
    issue(OP_MUL, 32'h12345, 32'hFFFF0001,
          model(OP_MUL, 32'h12345, 32'hFFFF0001));
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 200; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'($urandom_range(0, 40));
        1: y = 32'h0;
        2: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      run(o, x, y, model(o, x, y));
    end

    // reset in the middle of a MUL
    issue(OP_MUL, 32'h7, 32'h9, model(OP_MUL, 32'h7, 32'h9));
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_clear("reset_abort");
    scb.delete();
    repeat (3) begin
      @(posedge clk); #1;
      chk_clear("reset_hold");
    end
    rst_n = 1'b1;
    run(OP_ADD, 32'h2, 32'h3, mk(32'h5, 32'h0, 1'b0, 1'b0, 1));
    repeat (3) @(posedge clk);
    #1;

    n_cmp++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", scb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
